// File: rtl/ysyx_25040118_ifu_pf.sv
// Instruction fetch unit: sequential PC generation, in-order imem request/response, DEPTH-slot queue to decode.
// Optional IFU_MISALIGN_TRAP_EN: misaligned redirect targets become a single exception entry and halt fetch.
module ysyx_25040118_ifu_pf #(
    parameter int              XLEN     = 32,
    parameter int              INST_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_exc,
    input  logic              out_ready
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     PTR_ZERO = (PW + 1)'(0);
    localparam logic [PW:0]     PTR_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]     CAP      = (PW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    logic [XLEN-1:0]   fetch_pc_r, fetch_pc_n_s;
    logic [PW:0]       wp_r, fp_r, rp_r, drop_r;
    logic [PW:0]       wp_n_s, fp_n_s, rp_n_s, drop_n_s;
    logic              halt_r, halt_n_s;
    logic [XLEN-1:0]   slot_pc_r   [DEPTH];
    logic [INST_W-1:0] slot_inst_r [DEPTH];

    logic [PW-1:0] wp_idx_s, fp_idx_s, rp_idx_s;
    logic [PW:0]   occ_s, redir_sum_s, redir_drop_s;
    logic          credit_s, req_fire_s, out_fire_s, rsp_drop_s, rsp_fill_s, trap_s;

`ifdef IFU_MISALIGN_TRAP_EN
    localparam logic [XLEN-1:0] LOAD_MASK = '1;
    logic slot_exc_r [DEPTH];
    assign trap_s  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign out_exc = reset && slot_exc_r[rp_idx_s];
`else
    // Without the trap the low PC bits are simply forced to an aligned address.
    localparam logic [XLEN-1:0] LOAD_MASK = ~XLEN'(3);
    assign trap_s  = 1'b0;
    assign out_exc = 1'b0;
`endif

    assign wp_idx_s = wp_r[PW-1:0];
    assign fp_idx_s = fp_r[PW-1:0];
    assign rp_idx_s = rp_r[PW-1:0];

    // Allocated slots plus responses still to be discarded never exceed DEPTH, so PW+1 bits suffice.
    assign occ_s    = (wp_r - rp_r) + drop_r;
    assign credit_s = occ_s < CAP;

    assign imem_req_valid = reset && !redirect_valid && !halt_r && credit_s;
    assign imem_req_addr  = fetch_pc_r;
    assign out_valid      = reset && (fp_r != rp_r) && !redirect_valid;
    assign out_pc         = slot_pc_r[rp_idx_s];
    assign out_inst       = slot_inst_r[rp_idx_s];

    assign req_fire_s = imem_req_valid && imem_req_ready;
    assign out_fire_s = out_valid && out_ready;
    assign rsp_drop_s = reset && !redirect_valid && imem_rsp_valid && (drop_r != PTR_ZERO);
    assign rsp_fill_s = reset && !redirect_valid && imem_rsp_valid && (drop_r == PTR_ZERO) && (fp_r != wp_r);

    // Requests already issued but not yet filled become stale; a response arriving now retires one of them.
    assign redir_sum_s  = drop_r + (wp_r - fp_r);
    assign redir_drop_s = (imem_rsp_valid && (redir_sum_s != PTR_ZERO)) ? (redir_sum_s - PTR_ONE) : redir_sum_s;

    // Next-state computation for pointers, drop counter, halt and fetch PC.
    always_comb begin
        fetch_pc_n_s = fetch_pc_r;
        wp_n_s       = wp_r;
        fp_n_s       = fp_r;
        rp_n_s       = rp_r;
        drop_n_s     = drop_r;
        halt_n_s     = halt_r;
        if (redirect_valid) begin
            fetch_pc_n_s = redirect_pc & LOAD_MASK;
            wp_n_s       = trap_s ? PTR_ONE : PTR_ZERO;
            fp_n_s       = trap_s ? PTR_ONE : PTR_ZERO;
            rp_n_s       = PTR_ZERO;
            drop_n_s     = redir_drop_s;
            halt_n_s     = trap_s;
        end else begin
            fetch_pc_n_s = req_fire_s ? (fetch_pc_r + PC_STEP) : fetch_pc_r;
            wp_n_s       = req_fire_s ? (wp_r + PTR_ONE) : wp_r;
            fp_n_s       = rsp_fill_s ? (fp_r + PTR_ONE) : fp_r;
            rp_n_s       = out_fire_s ? (rp_r + PTR_ONE) : rp_r;
            drop_n_s     = rsp_drop_s ? (drop_r - PTR_ONE) : drop_r;
            halt_n_s     = halt_r;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r <= RESET_PC;
            wp_r       <= PTR_ZERO;
            fp_r       <= PTR_ZERO;
            rp_r       <= PTR_ZERO;
            drop_r     <= PTR_ZERO;
            halt_r     <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_n_s;
            wp_r       <= wp_n_s;
            fp_r       <= fp_n_s;
            rp_r       <= rp_n_s;
            drop_r     <= drop_n_s;
            halt_r     <= halt_n_s;
        end
    end

    // Slot payload writes; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (trap_s) begin
            slot_pc_r[0]   <= redirect_pc;
            slot_inst_r[0] <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            slot_exc_r[0]  <= 1'b1;
`endif
        end else begin
            if (req_fire_s) begin
                slot_pc_r[wp_idx_s] <= fetch_pc_r;
            end
            if (rsp_fill_s) begin
                slot_inst_r[fp_idx_s] <= imem_rsp_data;
`ifdef IFU_MISALIGN_TRAP_EN
                slot_exc_r[fp_idx_s]  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040118_ifu_pf.sv
// Self-checking bench for ysyx_25040118_ifu_pf: queue-level reference model, in-order memory model, directed and random phases.
module tb_ysyx_25040118_ifu_pf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exc;
    logic        out_ready = 1'b0;

    ysyx_25040118_ifu_pf #(
        .XLEN(32), .INST_W(32), .RESET_PC(32'h8000_0000), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;

    // Reference model: fetch PC, requests awaiting data, filled entries, stale-response count.
    logic [31:0] m_fetch_pc = 32'h8000_0000;
    bit          m_halt = 1'b0;
    int          m_drop = 0;
    logic [31:0] m_pend[$];
    ent_t        m_rdy[$];
    mrsp_t       mem_q[$];
    int          mem_lat_max = 1;
    int          cyc = 0;
    bit          e_req, e_out;

    logic [31:0] acc_q[$];
    logic [31:0] fire_q[$];

    int n_assert = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Drive one cycle's inputs at negedge, then compare DUT outputs with the model.
    task automatic drive(input bit rst_v, input bit redir, input logic [31:0] rpc,
                         input bit oready, input bit rready, input bit arsp);
        @(negedge clk);
        reset          = rst_v;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        out_ready      = oready;
        imem_req_ready = rready;
        if (rst_v && arsp && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (!rst_v) begin
            e_req = 1'b0;
            e_out = 1'b0;
        end else begin
            e_req = !redir && !m_halt && (m_pend.size() + m_rdy.size() + m_drop < DEPTH);
            e_out = (m_rdy.size() > 0) && !redir;
        end
        #1;
        chk("req_valid", imem_req_valid, e_req);
        if (e_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("out_valid", out_valid, e_out);
        if (e_out) begin
            chk("out_pc", out_pc, m_rdy[0].pc);
            chk("out_inst", out_inst, m_rdy[0].inst);
            chk("out_exc", out_exc, m_rdy[0].exc);
        end
        if (!rst_v) chk("rst_out_exc", out_exc, 1'b0);
        if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
        if (out_valid && out_ready) fire_q.push_back(out_pc);
    endtask

    // Advance model and memory at the clock edge.
    task automatic step();
        int d;
        @(posedge clk);
        if (!reset) begin
            m_fetch_pc = 32'h8000_0000;
            m_halt     = 1'b0;
            m_drop     = 0;
            m_pend.delete();
            m_rdy.delete();
            mem_q.delete();
        end else begin
            if (imem_rsp_valid) void'(mem_q.pop_front());
            if (redirect_valid) begin
                d = m_drop + m_pend.size() - (imem_rsp_valid ? 1 : 0);
                m_drop = (d < 0) ? 0 : d;
                m_pend.delete();
                m_rdy.delete();
                m_halt = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                m_fetch_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    m_halt = 1'b1;
                    m_rdy.push_back('{pc: redirect_pc, inst: 32'h0, exc: 1'b1});
                end
`else
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
`endif
            end else begin
                if (e_out && out_ready) void'(m_rdy.pop_front());
                if (imem_rsp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_pend.size() > 0) m_rdy.push_back('{pc: m_pend.pop_front(), inst: imem_rsp_data, exc: 1'b0});
                end
                if (e_req && imem_req_ready) begin
                    m_pend.push_back(m_fetch_pc);
                    mem_q.push_back('{data: $urandom, due: cyc + $urandom_range(1, mem_lat_max)});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick(input bit rst_v, input bit redir, input logic [31:0] rpc,
                        input bit oready, input bit rready, input bit arsp);
        drive(rst_v, redir, rpc, oready, rready, arsp);
        step();
    endtask

    initial begin
        logic [31:0] tgt;
        // Reset held three cycles, then fetch starts at the reset PC.
        mem_lat_max = 1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        acc_q.delete();
        fire_q.delete();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rst_release_req_valid", imem_req_valid, 1'b1);
        chk("rst_release_req_addr", imem_req_addr, 32'h8000_0000);
        step();

        // Streaming with single-cycle memory and a always-ready decoder.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("stream_acc0", acc_q[0], 32'h8000_0000);
        chk("stream_acc1", acc_q[1], 32'h8000_0004);
        chk("stream_acc2", acc_q[2], 32'h8000_0008);
        chk("stream_first_out", fire_q[0], 32'h8000_0000);
        chk("stream_out_count_ok", fire_q.size() >= 15, 1'b1);
        for (int i = 0; i + 1 < fire_q.size(); i++) chk("stream_pc_step", fire_q[i+1] - fire_q[i], 32'd4);

        // Backpressure: exactly DEPTH requests, then one more after a single dequeue.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        acc_q.delete();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("bp_accepted", acc_q.size(), 4);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("bp_full_no_req", imem_req_valid, 1'b0);
        step();
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("bp_one_more", acc_q.size(), 5);
        chk("bp_fifth_addr", acc_q[4], 32'h8000_0010);

        // Redirect with two requests outstanding: both responses must be discarded.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        acc_q.delete();
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("redir_outstanding", acc_q.size(), 2);
        drive(1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0);
        chk("redir_cycle_no_req", imem_req_valid, 1'b0);
        step();
        fire_q.delete();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("redir_acc_target", acc_q[2], 32'h8000_0100);
        chk("redir_first_out", fire_q[0], 32'h8000_0100);
        chk("redir_second_out", fire_q[1], 32'h8000_0104);

        // Reset with a full queue: outputs clear and fetch restarts at the reset PC.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_req_valid", imem_req_valid, 1'b1);
        chk("midrst_req_addr", imem_req_addr, 32'h8000_0000);
        step();

        // Misaligned redirect target.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 32'h8000_0102, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("trap_out_valid", out_valid, 1'b1);
        chk("trap_out_pc", out_pc, 32'h8000_0102);
        chk("trap_out_exc", out_exc, 1'b1);
        chk("trap_no_req", imem_req_valid, 1'b0);
        step();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("trap_still_halted", imem_req_valid, 1'b0);
        step();
        tick(1'b1, 1'b1, 32'h8000_0200, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("trap_resume_valid", imem_req_valid, 1'b1);
        chk("trap_resume_addr", imem_req_addr, 32'h8000_0200);
        step();
`else
        chk("misalign_req_valid", imem_req_valid, 1'b1);
        chk("misalign_req_addr", imem_req_addr, 32'h8000_0100);
        chk("misalign_exc_zero", out_exc, 1'b0);
        step();
`endif

        // Random traffic, including a target that wraps the 32-bit PC.
        mem_lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = 32'h8000_0000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                1:       tgt = 32'hFFFF_FFF0;
                2:       tgt = 32'h8000_0102 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                default: tgt = $urandom;
            endcase
            tick($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, tgt,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25040118_ifu_pf.md
Name: ysyx_25040118_ifu_pf

Overview:
Next-generation instruction fetch unit. Generates sequential fetch PCs and issues them on a valid/ready instruction-memory request channel, accepting in-order responses. Buffers fetched {pc, inst} pairs in a DEPTH-entry slot queue toward decode. Supports redirect (branch/jump/trap) with flush and squashing of stale in-flight responses. Sits between the PC-redirect logic of EXU/WBU and the IDU.

Parameters:
XLEN, 32, PC/address width
INST_W, 32, instruction width
RESET_PC, 32'h8000_0000, fetch PC after reset
DEPTH, 4, slot-queue depth; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
redirect_valid  in  1  redirect request this cycle
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid (in order, one per accepted request)
imem_rsp_data  in  INST_W  fetched instruction
out_valid  out  1  entry available to decode
out_pc  out  XLEN  pc of head entry
out_inst  out  INST_W  instruction of head entry
out_exc  out  1  head entry is misaligned-fetch exception
out_ready  in  1  decode accepts head entry

Behaviour:
- State: fetch_pc, DEPTH slots {pc, inst, exc}; pointers wp (alloc), fp (fill), rp (read), each log2(DEPTH)+1 bits with a wrap bit; drop counter (0..DEPTH); halt flag.
- Reset (reset==0 at posedge): fetch_pc=RESET_PC; wp=fp=rp=0; drop=0; halt=0. While reset==0, imem_req_valid=0, out_valid=0, out_exc=0. The first cycle after release: imem_req_valid=1, addr=RESET_PC.
- Credit: imem_req_valid = !redirect_valid && !halt && ((wp-rp)+drop < DEPTH). imem_req_addr = fetch_pc.
- Request fire (valid&&ready): slot[wp].pc=fetch_pc; wp++; fetch_pc += 4, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0).
- Response: if drop>0, drop-- and discard data. Else if fp!=wp, slot[fp].inst=data, exc=0, fp++. Else ignore (protocol violation, no state change).
- Output: out_valid = (fp!=rp) && !redirect_valid; out_pc/inst/exc = slot[rp]. Fire (out_valid&&out_ready) -> rp++. Zero-latency bypass is not provided: a response is visible on out_* the cycle after it arrives.
- Simultaneous request fire, response and dequeue in one cycle: all three apply.
- Full: (wp-rp)+drop==DEPTH -> no request; the queue drains only via out_ready.
- Redirect (highest priority, takes effect at the next edge): drop_next = drop + (wp-fp) - (imem_rsp_valid ? 1 : 0), saturating at 0. wp=fp=rp=0; fetch_pc=redirect_pc; halt=0. In the redirect cycle, no request is issued and no dequeue occurs.
- Reset mid-operation discards drop. The memory side must likewise be reset.

Optional Feature:
IFU_MISALIGN_TRAP_EN
- Defined: a redirect with redirect_pc[1:0]!=0 sets halt=1 and allocates and fills one slot immediately {pc=redirect_pc, inst=0, exc=1}. No request is issued until the next redirect. out_exc=1 while that entry is at the head.
- Undefined: out_exc is constant 0. redirect_pc[1:0] is cleared when loaded into fetch_pc.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> imem_req_addr=0x8000_0000 with req_valid=1. Accepted requests give addrs 0x8000_0000, 0x8000_0004, ...
- Streaming: req_ready=1, 1-cycle response latency, out_ready=1 -> out_pc advances by 4 each cycle after fill, out_inst matches imem_rsp_data in order.
- Backpressure: out_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then req_valid=0. Raising out_ready one cycle -> one more request issued.
- Redirect with 2 outstanding: redirect to 0x8000_0100 -> the next 2 responses are discarded, first out_pc=0x8000_0100, and no stale instruction appears.
- Reset mid-stream with a full queue: out_valid=0 the next cycle and fetch restarts at 0x8000_0000.
- IFU_MISALIGN_TRAP_EN: redirect to 0x8000_0102 -> out_valid=1, out_pc=0x8000_0102, out_exc=1, req_valid stays 0. A redirect to 0x8000_0200 resumes fetch.
